// File: rtl/line_raster.sv
// Bresenham line rasterizer: endpoint pair in, one pixel
// coordinate per cycle out, off-screen pixels skipped silently.
module line_raster #(
  parameter int COORD_W = 12,
  parameter int H_RES   = 800,
  parameter int V_RES   = 600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic signed [COORD_W-1:0] iX0,
  input  logic signed [COORD_W-1:0] iY0,
  input  logic signed [COORD_W-1:0] iX1,
  input  logic signed [COORD_W-1:0] iY1,
  output logic                      oPixValid,
  input  logic                      iPixReady,
  output logic signed [COORD_W-1:0] oPixX,
  output logic signed [COORD_W-1:0] oPixY,
  output logic                      oPixLast,
  output logic                      oBusy,
  output logic                      oLineDone
);

  localparam int W = COORD_W;
  localparam logic signed [W-1:0] HMAX = W'(H_RES);
  localparam logic signed [W-1:0] VMAX = W'(V_RES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
  } state_t;

  state_t state, state_nxt;

  logic signed [W-1:0] x0, y0, x1, y1, x, y;
  logic        [W:0]   dx;
  logic signed [W+1:0] dy, err;
  logic                sxn, syn;

  logic signed [W:0]   ddx, ddy;
  logic        [W:0]   adx, ady;
  logic signed [W+1:0] dy_s, err_s, dxs, err_nxt;
  logic signed [W+2:0] e2;
  logic step_x, step_y, on, at_end, adv;

  assign ddx = $signed({x1[W-1], x1}) - $signed({x0[W-1], x0});
  assign ddy = $signed({y1[W-1], y1}) - $signed({y0[W-1], y0});
  assign adx = ddx[W] ? $unsigned(-ddx) : $unsigned(ddx);
  assign ady = ddy[W] ? $unsigned(-ddy) : $unsigned(ddy);
  assign dy_s  = -$signed({1'b0, ady});
  assign err_s = $signed({1'b0, adx}) + dy_s;

  // Both step decisions look at the pre-advance error term
  assign dxs    = $signed({1'b0, dx});
  assign e2     = $signed({err, 1'b0});
  assign step_x = e2 >= $signed({dy[W+1], dy});
  assign step_y = e2 <= $signed({dxs[W+1], dxs});
  assign err_nxt = err
                 + (step_x ? dy  : '0)
                 + (step_y ? dxs : '0);

  assign on = !x[W-1] && (x < HMAX)
           && !y[W-1] && (y < VMAX);
  assign at_end = (x == x1) && (y == y1);
  assign adv = (state == DRAW) && (!on || iPixReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oLineDone = 1'b0;
    unique case (state)
      IDLE:  if (iValid) state_nxt = SETUP;
      SETUP: state_nxt = DRAW;
      DRAW: begin
        if (adv && at_end) begin
          state_nxt = IDLE;
          oLineDone = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0  <= '0;
      y0  <= '0;
      x1  <= '0;
      y1  <= '0;
      x   <= '0;
      y   <= '0;
      dx  <= '0;
      dy  <= '0;
      err <= '0;
      sxn <= 1'b0;
      syn <= 1'b0;
    end else begin
      if (state == IDLE && iValid) begin
        x0 <= iX0;
        y0 <= iY0;
        x1 <= iX1;
        y1 <= iY1;
      end
      if (state == SETUP) begin
        dx  <= adx;
        dy  <= dy_s;
        err <= err_s;
        sxn <= !(x0 < x1);
        syn <= !(y0 < y1);
        x   <= x0;
        y   <= y0;
      end
      if (adv) begin
        err <= err_nxt;
        if (step_x) x <= sxn ? x - W'(1) : x + W'(1);
        if (step_y) y <= syn ? y - W'(1) : y + W'(1);
      end
    end
  end

  assign oReady    = (state == IDLE);
  assign oBusy     = (state != IDLE);
  assign oPixValid = (state == DRAW) && on;
  assign oPixLast  = oPixValid && at_end;
  assign oPixX     = x;
  assign oPixY     = y;

endmodule

// File: tb/tb_line_raster.sv
// Scoreboard bench for line_raster: expected pixels queued
// per line, observed transfers collected and compared.
module tb_line_raster;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iValid = 1'b0;
  logic iPixReady = 1'b1;
  logic signed [11:0] iX0 = '0, iY0 = '0;
  logic signed [11:0] iX1 = '0, iY1 = '0;
  logic oReady, oPixValid, oPixLast, oBusy, oLineDone;
  logic signed [11:0] oPixX, oPixY;

  line_raster dut (
    .clk(clk), .rst_n(rst_n),
    .iValid(iValid), .oReady(oReady),
    .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1),
    .oPixValid(oPixValid), .iPixReady(iPixReady),
    .oPixX(oPixX), .oPixY(oPixY),
    .oPixLast(oPixLast), .oBusy(oBusy),
    .oLineDone(oLineDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    logic last;
    int rel;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];
  int pass = 0;
  int total = 0;
  int cyc = 0;
  int acc = 0;
  int done_rel;
  int unstable;
  bit finished;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic pix_t mk(int x, int y, logic l, int r);
    pix_t p;
    p.x = x; p.y = y; p.last = l; p.rel = r;
    return p;
  endfunction

  task automatic start_line(int x0, int y0, int x1, int y1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oReady) break;
    end
    iValid = 1'b1;
    iX0 = 12'(x0); iY0 = 12'(y0);
    iX1 = 12'(x1); iY1 = 12'(y1);
    @(posedge clk);
    #1;
    acc = cyc;
    iValid = 1'b0;
    iX0 = 12'($urandom); iY0 = 12'($urandom);
    iX1 = 12'($urandom); iY1 = 12'($urandom);
  endtask

  // Gathers transfers until oLineDone; rel 2 is the first pixel cycle
  task automatic collect(bit rnd);
    bit ps;
    logic pv, pl;
    logic signed [11:0] px, py;
    int rel;
    ps = 0; pv = 0; pl = 0; px = '0; py = '0;
    finished = 0;
    done_rel = -1;
    unstable = 0;
    obs_q.delete();
    for (int i = 0; i < 300; i++) begin
      iPixReady = rnd ? 1'($urandom) : 1'b1;
      @(negedge clk);
      rel = cyc - acc + 1;
      if (ps && (oPixValid !== pv || oPixX !== px ||
                 oPixY !== py || oPixLast !== pl))
        unstable++;
      if (oPixValid && iPixReady)
        obs_q.push_back(mk(oPixX, oPixY, oPixLast, rel));
      ps = oPixValid && !iPixReady;
      pv = oPixValid; pl = oPixLast;
      px = oPixX; py = oPixY;
      if (oLineDone) begin
        done_rel = rel;
        finished = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    iPixReady = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (oReady !== 1'b1 || oBusy !== 1'b0)
      $display("FAIL reset ready/busy: got %b/%b want 1/0",
               oReady, oBusy);
    else pass++;
    total++;
    if (oPixValid !== 1'b0 || oPixLast !== 1'b0 ||
        oLineDone !== 1'b0)
      $display("FAIL reset valid/last/done: got %b%b%b want 000",
               oPixValid, oPixLast, oLineDone);
    else pass++;
    total++;
    if (oPixX !== 12'sd0 || oPixY !== 12'sd0)
      $display("FAIL reset xy: got (%0d,%0d) want (0,0)",
               oPixX, oPixY);
    else pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_point();
    pix_t e, o;
    exp_q.push_back(mk(100, 100, 1'b1, 2));
    start_line(100, 100, 100, 100);
    collect(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL point pix: got none want (%0d,%0d)",
                 e.x, e.y);
      else begin
        o = obs_q.pop_front();
        if (o.x != e.x || o.y != e.y || o.last !== e.last ||
            o.rel != e.rel)
          $display("FAIL point pix: got (%0d,%0d,%b)@%0d want (%0d,%0d,%b)@%0d",
                   o.x, o.y, o.last, o.rel, e.x, e.y, e.last, e.rel);
        else pass++;
      end
    end
    total++;
    if (!finished || done_rel != 2)
      $display("FAIL point done: got cycle %0d want 2", done_rel);
    else pass++;
    @(negedge clk);
    total++;
    if (oReady !== 1'b1)
      $display("FAIL point ready: got %b want 1", oReady);
    else pass++;
  endtask

  task automatic test_horizontal();
    pix_t e, o;
    for (int i = 0; i < 5; i++)
      exp_q.push_back(mk(10 + i, 20, 1'(i == 4), 2 + i));
    start_line(10, 20, 14, 20);
    collect(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL horiz pix: got none want (%0d,%0d)",
                 e.x, e.y);
      else begin
        o = obs_q.pop_front();
        if (o.x != e.x || o.y != e.y || o.last !== e.last ||
            o.rel != e.rel)
          $display("FAIL horiz pix: got (%0d,%0d,%b)@%0d want (%0d,%0d,%b)@%0d",
                   o.x, o.y, o.last, o.rel, e.x, e.y, e.last, e.rel);
        else pass++;
      end
    end
    total++;
    if (obs_q.size() != 0 || !finished)
      $display("FAIL horiz extra/done: got %0d extra done=%b want 0 1",
               obs_q.size(), finished);
    else pass++;
  endtask

  task automatic test_steep(bit rnd);
    pix_t e, o;
    int sx[7] = '{5, 5, 4, 4, 4, 3, 3};
    int sy[7] = '{10, 9, 8, 7, 6, 5, 4};
    for (int i = 0; i < 7; i++)
      exp_q.push_back(mk(sx[i], sy[i], 1'(i == 6),
                         rnd ? -1 : 2 + i));
    start_line(5, 10, 3, 4);
    collect(rnd);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL steep%0d pix: got none want (%0d,%0d)",
                 rnd, e.x, e.y);
      else begin
        o = obs_q.pop_front();
        if (o.x != e.x || o.y != e.y || o.last !== e.last ||
            (e.rel >= 0 && o.rel != e.rel))
          $display("FAIL steep%0d pix: got (%0d,%0d,%b)@%0d want (%0d,%0d,%b)@%0d",
                   rnd, o.x, o.y, o.last, o.rel,
                   e.x, e.y, e.last, e.rel);
        else pass++;
      end
    end
    total++;
    if (obs_q.size() != 0 || !finished)
      $display("FAIL steep%0d extra/done: got %0d extra done=%b want 0 1",
               rnd, obs_q.size(), finished);
    else pass++;
    total++;
    if (unstable != 0)
      $display("FAIL steep%0d stall stable: got %0d changes want 0",
               rnd, unstable);
    else pass++;
  endtask

  task automatic test_clip();
    pix_t e, o;
    for (int i = 0; i < 3; i++)
      exp_q.push_back(mk(i, 0, 1'(i == 2), 4 + i));
    start_line(-2, 0, 2, 0);
    collect(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL clipl pix: got none want (%0d,%0d)",
                 e.x, e.y);
      else begin
        o = obs_q.pop_front();
        if (o.x != e.x || o.y != e.y || o.last !== e.last ||
            o.rel != e.rel)
          $display("FAIL clipl pix: got (%0d,%0d,%b)@%0d want (%0d,%0d,%b)@%0d",
                   o.x, o.y, o.last, o.rel, e.x, e.y, e.last, e.rel);
        else pass++;
      end
    end
    for (int i = 0; i < 5; i++)
      exp_q.push_back(mk(795 + i, 599, 1'b0, 2 + i));
    start_line(795, 599, 805, 599);
    collect(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL clipr pix: got none want (%0d,%0d)",
                 e.x, e.y);
      else begin
        o = obs_q.pop_front();
        if (o.x != e.x || o.y != e.y || o.last !== e.last ||
            o.rel != e.rel)
          $display("FAIL clipr pix: got (%0d,%0d,%b)@%0d want (%0d,%0d,%b)@%0d",
                   o.x, o.y, o.last, o.rel, e.x, e.y, e.last, e.rel);
        else pass++;
      end
    end
    total++;
    if (obs_q.size() != 0 || done_rel != 12)
      $display("FAIL clipr done: got %0d extra done@%0d want 0 @12",
               obs_q.size(), done_rel);
    else pass++;
  endtask

  task automatic test_reset_mid();
    bit bad;
    start_line(0, 0, 50, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (oPixValid !== 1'b1 || oPixX !== 12'sd2)
      $display("FAIL midrst pre: got v=%b x=%0d want v=1 x=2",
               oPixValid, oPixX);
    else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if (oPixValid !== 1'b0 || oBusy !== 1'b0 || oPixX !== 12'sd0)
      $display("FAIL midrst abort: got v=%b busy=%b x=%0d want 0 0 0",
               oPixValid, oBusy, oPixX);
    else pass++;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (oPixValid !== 1'b0 || oLineDone !== 1'b0) bad = 1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bad || oReady !== 1'b1)
      $display("FAIL midrst idle: got quiet=%b ready=%b want 1 1",
               !bad, oReady);
    else pass++;
    start_line(7, 3, 9, 3);
    collect(0);
    total++;
    if (obs_q.size() != 3 || obs_q[0].x != 7 || obs_q[0].rel != 2)
      $display("FAIL midrst next: got n=%0d x0=%0d want n=3 x0=7",
               obs_q.size(),
               obs_q.size() > 0 ? obs_q[0].x : -999);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_point();
    test_horizontal();
    test_steep(0);
    test_steep(1);
    test_clip();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/line_raster.md
# line_raster

Bresenham line rasterizer converting a pair of screen-space endpoints into a stream of pixel coordinates, one per cycle. It sits directly downstream of the CORDIC rotation/offset stage, which supplies rotated and screen-offset vertex coordinates. It feeds the framebuffer writer that the VGA scan-out reads, replacing single-dot plotting with connected wireframe edges. Pixels outside the visible area are iterated but never emitted.

## Interface

- COORD_W, 12, signed coordinate width in bits (range -2048..2047).
- H_RES, 800, visible width; x is on-screen iff 0 <= x < H_RES.
- V_RES, 600, visible height; y is on-screen iff 0 <= y < V_RES.

- clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  in  1  asynchronous active-low reset.
- iValid  in  1  endpoint pair valid.
- oReady  out  1  block can accept a line; high only in IDLE.
- iX0, iY0, iX1, iY1  in  COORD_W signed  line start and end point; sampled only on handshake.
- oPixValid  out  1  oPixX/oPixY hold an on-screen pixel.
- iPixReady  in  1  downstream accepts the pixel.
- oPixX, oPixY  out  COORD_W signed  current pixel.
- oPixLast  out  1  current pixel is the line endpoint; qualified by oPixValid.
- oBusy  out  1  line in progress (state != IDLE).
- oLineDone  out  1  one-cycle pulse when a line finishes, including fully clipped lines.

## Operation

- States: IDLE, SETUP, DRAW.
- IDLE
  - oReady=1.
  - iValid && oReady latches all four endpoints and moves to SETUP.
- SETUP (one cycle) computes:
  - dx = |x1-x0| (COORD_W+1 bits).
  - dy = -|y1-y0| (signed, COORD_W+2 bits).
  - sx = +1 if x0<x1, else -1.
  - sy = +1 if y0<y1, else -1.
  - err = dx+dy (signed, COORD_W+2 bits).
  - x=x0, y=y0.
  - Moves to DRAW.
- DRAW
  - The candidate pixel is (x,y).
  - A pixel advances when it is on-screen and iPixReady=1, or when it is off-screen (advances unconditionally, oPixValid=0).
  - Advance step, with e2=2*err (COORD_W+3 bits):
    - if e2 >= dy: err += dy, x += sx.
    - if e2 <= dx: err += dx, y += sy.
    - Both updates use the pre-advance err and apply in the same cycle.
  - Advancing the endpoint pixel (x==x1 && y==y1) returns to IDLE and pulses oLineDone in that same cycle.
- Pixel count is max(dx,|y1-y0|)+1. Degenerate line (x0==x1, y0==y1) emits exactly one pixel with oPixLast=1.
- oPixLast=1 whenever (x,y) equals the endpoint. If the endpoint is off-screen, no oPixLast is emitted; consumers use oLineDone.
- iValid outside IDLE is ignored. Input ports may change freely after acceptance.
- No arithmetic wraparound: internal widths cover the full signed input range.

## Timing

- Reset values:
  - State IDLE.
  - oReady=1.
  - oPixValid=0, oPixLast=0, oBusy=0, oLineDone=0.
  - oPixX=0, oPixY=0.
- Accept at edge N; SETUP during cycle N+1; first candidate pixel presented in cycle N+2.
- Throughput: 1 pixel/cycle with iPixReady held high.
- Back-to-back lines: oReady returns one cycle after the last advance. Minimum per-line overhead is 2 cycles (IDLE accept, SETUP).
- Handshake rules:
  - oPixValid, oPixX, oPixY and oPixLast hold stable while oPixValid=1 and iPixReady=0.
  - oPixValid must not depend combinationally on iPixReady.
  - oPixX, oPixY and oPixLast are driven from registered state only.
- Reset asserted mid-line aborts immediately: outputs go to reset values and no further pixels or oLineDone are produced.

## Test plan

- Point (100,100)->(100,100), iPixReady=1:
  - One pixel (100,100) with oPixLast=1, in cycle N+2.
  - oLineDone pulses in that cycle; oReady=1 in N+3.
- Horizontal (10,20)->(14,20), iPixReady=1:
  - x=10..14 at y=20 on five consecutive cycles starting N+2.
  - oPixLast only on (14,20).
- Steep negative (5,10)->(3,4):
  - Exact sequence (5,10),(5,9),(4,8),(4,7),(4,6),(3,5),(3,4).
  - oPixLast on the last pixel.
- Backpressure: repeat the steep case with iPixReady toggling pseudo-randomly.
  - Same 7-pixel sequence.
  - Outputs stable during every stall.
- Clipping (-2,0)->(2,0):
  - Only (0,0),(1,0),(2,0) valid, first at N+4.
  - Line (795,599)->(805,599) emits (795..799,599), no oPixLast; oLineDone fires after 11 iterations.
- Reset mid-line: assert rst_n low during pixel 3 of (0,0)->(50,0).
  - oPixValid=0 immediately, oReady=1 after release.
  - A new line accepted afterward starts from its own x0.
